// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences a PLL out of reset, waits for its lock indication to stay
// stable, then releases the downstream system reset. Loss of lock drops the
// system reset and requalifies the lock. A PLL that never locks is reset
// again after a timeout.
//
// Optional feature macro: PLL_SUP_LOSS_CNT_EN
//   defined   -> loss_cnt is a saturating count of lock losses seen in RUN
//   undefined -> loss_cnt is tied to zero and no counter register exists
module pll_lock_supervisor #(
  parameter int RST_PULSE = 4,   // pll_rst assertion length in clk cycles (>=2)
  parameter int LOCK_WAIT = 16,  // consecutive locked cycles before release (>=2)
  parameter int TIMEOUT   = 64,  // cycles without lock before re-resetting the PLL (>=2)
  parameter int CNT_W     = 8    // width of loss_cnt
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic [CNT_W-1:0] loss_cnt,
  output logic             retry
);

  // The shared dwell counter must hold the longest dwell minus one.
  localparam int MAX_AB    = (RST_PULSE > LOCK_WAIT) ? RST_PULSE : LOCK_WAIT;
  localparam int MAX_DWELL = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
  localparam int CW        = $clog2(MAX_DWELL + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      sync_q;
  logic            locked_s;
  logic            timeout_hit;

  assign locked_s = sync_q[1];

  // Two-flop synchronizer: the only place pll_locked is sampled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pll_locked};
  end

  // State and dwell-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; the counter restarts from zero on every state change.
  // NOTE: every signal written here gets a default first, otherwise a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt + 1'b1;
    timeout_hit = 1'b0;
    unique case (state)
      S_PLL_RST: begin
        if (cnt == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt == TMO_LAST) begin
          state_d     = S_PLL_RST;
          timeout_hit = 1'b1;
        end
      end
      S_STABLE: begin
        // A captured drop restarts qualification and the lock timeout.
        if (!locked_s)             state_d = S_WAIT_LOCK;
        else if (cnt == LOCK_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
      end
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state) cnt_d = '0;
  end

  // Output registers decoded from the next state so they switch on the same
  // edge as the state itself and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      retry     <= 1'b0;
    end else begin
      pll_rst   <= (state_d == S_PLL_RST);
      sys_rst_n <= (state_d == S_RUN);
      retry     <= timeout_hit;
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q;

  // Saturating count of lock losses taken while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (state == S_RUN && !locked_s && loss_q != '1) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
// Drives pll_locked on the falling clock edge, predicts the outputs after
// the following rising edge with a timeline-based reference model, and queues
// that prediction. A monitor compares the DUT outputs shortly after each
// rising edge against the queued prediction. Directed scenarios also measure
// event edges directly against fixed edge numbers.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE = 4;
  localparam int LOCK_WAIT = 16;
  localparam int TIMEOUT   = 64;
  localparam int CNT_W     = 8;
  localparam int LOSS_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst_n;
  logic [CNT_W-1:0] loss_cnt;
  logic             retry;

  pll_lock_supervisor #(
    .RST_PULSE (RST_PULSE),
    .LOCK_WAIT (LOCK_WAIT),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .loss_cnt   (loss_cnt),
    .retry      (retry)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_RST, M_WAIT, M_STABLE, M_RUN} mphase_t;

  typedef struct {
    bit pll_rst;
    bit sys_rst_n;
    bit retry;
    int loss;
  } exp_t;

  exp_t    exp_q[$];
  bit      samples[$];   // samples[i] = pll_locked seen at edge i+1
  mphase_t phase;
  int      edge_no;      // rising edges since reset release
  int      phase_start;  // edge on which the current phase was entered
  int      losses;

  function automatic void model_reset();
    edge_no     = 0;
    phase       = M_RST;
    phase_start = 0;
    losses      = 0;
    samples.delete();
  endfunction

  function automatic int expected_loss();
`ifdef PLL_SUP_LOSS_CNT_EN
    return (losses > LOSS_MAX) ? LOSS_MAX : losses;
`else
    return 0;
`endif
  endfunction

  // Predict the state after the next rising edge given the value on pll_locked.
  function automatic exp_t model_edge(input bit v);
    exp_t e;
    bit   ls;
    int   nth;
    bit   tmo;
    edge_no++;
    // Synchronized lock seen at edge n is the raw value captured at edge n-2.
    ls  = (edge_no >= 3) ? samples[edge_no - 3] : 1'b0;
    samples.push_back(v);
    nth = edge_no - phase_start;   // this is the nth edge spent in the phase
    tmo = 1'b0;
    case (phase)
      M_RST:    if (nth == RST_PULSE) begin phase = M_WAIT; phase_start = edge_no; end
      M_WAIT:   if (ls) begin phase = M_STABLE; phase_start = edge_no; end
                else if (nth == TIMEOUT) begin phase = M_RST; phase_start = edge_no; tmo = 1'b1; end
      M_STABLE: if (!ls) begin phase = M_WAIT; phase_start = edge_no; end
                else if (nth == LOCK_WAIT) begin phase = M_RUN; phase_start = edge_no; end
      M_RUN:    if (!ls) begin phase = M_WAIT; phase_start = edge_no; losses++; end
      default:  ;
    endcase
    e.pll_rst   = (phase == M_RST);
    e.sys_rst_n = (phase == M_RUN);
    e.retry     = tmo;
    e.loss      = expected_loss();
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called on a falling edge; returns on the next falling edge.
  task automatic step(input bit v);
    pll_locked = v;
    exp_q.push_back(model_edge(v));
    @(negedge clk);
  endtask

  // Called on a falling edge; releases reset on a later falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_pll_rst"},   pll_rst,   1);
    check({tag, "_rst_sys_rst_n"}, sys_rst_n, 0);
    check({tag, "_rst_loss_cnt"},  loss_cnt,  0);
    check({tag, "_rst_retry"},     retry,     0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pll_rst",   pll_rst,   e.pll_rst);
        check("sb_sys_rst_n", sys_rst_n, e.sys_rst_n);
        check("sb_retry",     retry,     e.retry);
        check("sb_loss_cnt",  loss_cnt,  e.loss);
      end
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    int fall_at, rise_at, low_at, retries, r1, r2, high_seen, lvl, dur;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);

    // Always locked: PLL reset drops at edge 4, system reset releases at 21.
    do_reset("lock");
    fall_at = -1; rise_at = -1; retries = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b1);
      if (fall_at < 0 && !pll_rst)  fall_at = k;
      if (rise_at < 0 && sys_rst_n) rise_at = k;
      if (retry) retries++;
    end
    check("lock_pll_rst_fall_edge",  fall_at, 4);
    check("lock_sys_rst_rise_edge",  rise_at, 21);
    check("lock_retry_count",        retries, 0);

    // Loss in RUN for 10 cycles: 3-edge drop latency, requalify after relock.
    low_at = -1; rise_at = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0);
      if (low_at < 0 && !sys_rst_n) low_at = k;
    end
    for (int k = 1; k <= 30; k++) begin
      step(1'b1);
      if (rise_at < 0 && sys_rst_n) rise_at = k;
    end
    check("loss_drop_latency", low_at, 3);
    check("loss_relock_edge",  rise_at, 19);
`ifdef PLL_SUP_LOSS_CNT_EN
    check("loss_cnt_after_one", loss_cnt, 1);
`else
    check("loss_cnt_after_one", loss_cnt, 0);
`endif

    // Never locked: retry and PLL reset at edges 68 and 136.
    do_reset("nolock");
    r1 = -1; r2 = -1; high_seen = 0;
    for (int k = 1; k <= 150; k++) begin
      step(1'b0);
      if (retry) begin
        if (r1 < 0) begin
          r1 = k;
          check("nolock_pll_rst_at_retry", pll_rst, 1);
        end else if (r2 < 0) begin
          r2 = k;
        end
      end
      if (sys_rst_n) high_seen++;
    end
    check("nolock_retry_first",  r1, 68);
    check("nolock_retry_second", r2, 136);
    check("nolock_sys_rst_high", high_seen, 0);

    // One-cycle drop while STABLE at cnt=10: fresh qualification, RUN at 32.
    do_reset("glitch");
    rise_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step(k != 13);
      if (rise_at < 0 && sys_rst_n) rise_at = k;
    end
    check("glitch_requal_edge", rise_at, 32);

    // Randomized lock behaviour, including stretches long enough to time out.
    do_reset("rand");
    lvl = 0;
    for (int n = 0; n < 3000; ) begin
      dur = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 140) : $urandom_range(1, 30);
      for (int k = 0; k < dur; k++) step(lvl[0]);
      n  += dur;
      lvl = 1 - lvl;
    end

    // 300 losses: the counter saturates.
    do_reset("sat");
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 25; k++) step(1'b1);
      for (int k = 0; k < 3; k++)  step(1'b0);
    end
    for (int k = 0; k < 25; k++) step(1'b1);
`ifdef PLL_SUP_LOSS_CNT_EN
    check("sat_loss_cnt", loss_cnt, LOSS_MAX);
`else
    check("sat_loss_cnt", loss_cnt, 0);
`endif
    check("sat_in_run", sys_rst_n, 1);

    // Reset pulse mid-RUN: outputs return to reset values at once.
    do_reset("midrun");
    for (int k = 0; k < 25; k++) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
